// File: rtl/booth_mul_sched.sv
// -----------------------------------------------------------------------------
// booth_mul_sched
//
// Sequencer and round-robin arbiter for a shared radix-4 Booth multiplier
// datapath (A/Q/M registers, adder/subtractor, M/2M operand mux). One of N_REQ
// requesters is granted the datapath. The sequencer then runs a load step and
// WIDTH/2 evaluate/shift iterations, and pulses done back to the winner.
//
// Optional feature (compile-time macro BOOTH_SCHED_PERF_CNT_EN):
//   When the macro is defined, the o_jobs_done output is added. It is a 16-bit
//   saturating count of completed (not aborted) jobs.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   WIDTH  operand width, even and >= 4; ITER = WIDTH/2 Booth iterations
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   i_req        per-requester request, held until done or abort
//   o_grant      one-hot grant (steers operand mux), zero when idle
//   o_done       one-cycle completion pulse to the granted requester
//   o_busy       high whenever the sequencer is not idle
//   i_q1         datapath Q[1]
//   i_q0         datapath Q[0]
//   i_q_m1       datapath Q[-1]
//   o_load_qm    load Q and M from operands; clear A and Q[-1]
//   o_load_a     write adder result into A
//   o_sub        adder subtracts (A - sel)
//   o_sel_2m     adder operand is 2M (else M)
//   o_jobs_done  completed-job count (only with BOOTH_SCHED_PERF_CNT_EN)
//   o_shift_aq   arithmetic shift A:Q:Q[-1] right by 2
// -----------------------------------------------------------------------------
module booth_mul_sched #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant,
    output logic [N_REQ-1:0] o_done,
    output logic             o_busy,
    input  logic             i_q1,
    input  logic             i_q0,
    input  logic             i_q_m1,
    output logic             o_load_qm,
    output logic             o_load_a,
    output logic             o_sub,
    output logic             o_sel_2m,
`ifdef BOOTH_SCHED_PERF_CNT_EN
    output logic [15:0]      o_jobs_done,
`endif
    output logic             o_shift_aq
);

    localparam int unsigned ITER  = WIDTH / 2;
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StEval  = 3'd2,
        StShift = 3'd3,
        StDone  = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_d;
    logic [N_REQ-1:0]   w_grant_d;
    logic [IDX_W-1:0]   w_gidx_d;
    logic [IDX_W-1:0]   w_rr_ptr_d;
    logic [CNT_W-1:0]   w_cnt_d;

    // -------------------------------------------------------------------------
    // Round-robin pick: first requester at or after the pointer, cyclically.
    // -------------------------------------------------------------------------
    logic               w_pick_found;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W:0]     w_cand;
    logic [N_REQ-1:0]   w_pick_onehot;

    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Extra bit holds pointer + offset before wrapping back into range.
            w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
            if (w_cand >= (IDX_W + 1)'(N_REQ)) begin
                w_cand = w_cand - (IDX_W + 1)'(N_REQ);
            end
            if (!w_pick_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_pick_onehot = N_REQ'(1) << w_pick_idx;

    // Pointer value that moves past the current owner (used on done and abort).
    logic [IDX_W-1:0]   w_rr_next;
    assign w_rr_next = (r_gidx == LAST_IDX) ? '0 : r_gidx + IDX_W'(1);

    // Owner still requesting; a drop mid-job aborts it.
    logic               w_req_held;
    assign w_req_held = i_req[r_gidx];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state;
        w_grant_d  = r_grant;
        w_gidx_d   = r_gidx;
        w_rr_ptr_d = r_rr_ptr;
        w_cnt_d    = r_cnt;

        case (r_state)
            StIdle: begin
                if (w_pick_found) begin
                    w_state_d = StLoad;
                    w_grant_d = w_pick_onehot;
                    w_gidx_d  = w_pick_idx;
                end
            end

            StLoad: begin
                if (!w_req_held) begin
                    w_state_d  = StIdle;
                    w_grant_d  = '0;
                    w_rr_ptr_d = w_rr_next;
                end else begin
                    w_cnt_d   = '0;
                    w_state_d = StEval;
                end
            end

            StEval: begin
                if (!w_req_held) begin
                    w_state_d  = StIdle;
                    w_grant_d  = '0;
                    w_rr_ptr_d = w_rr_next;
                end else begin
                    w_state_d = StShift;
                end
            end

            StShift: begin
                if (!w_req_held) begin
                    w_state_d  = StIdle;
                    w_grant_d  = '0;
                    w_rr_ptr_d = w_rr_next;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_d = StDone;
                end else begin
                    w_cnt_d   = r_cnt + CNT_W'(1);
                    w_state_d = StEval;
                end
            end

            StDone: begin
                w_state_d  = StIdle;
                w_grant_d  = '0;
                w_rr_ptr_d = w_rr_next;
            end

            default: begin
                w_state_d = StIdle;
                w_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_grant  <= w_grant_d;
            r_gidx   <= w_gidx_d;
            r_rr_ptr <= w_rr_ptr_d;
            r_cnt    <= w_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath controls, combinational from state (and the Booth triplet in
    // EVAL). The triplet encodes digit = -2*Q[1] + Q[0] + Q[-1] in {-2..2}.
    // -------------------------------------------------------------------------
    logic [2:0] w_triplet;
    assign w_triplet = {i_q1, i_q0, i_q_m1};

    always_comb begin
        o_load_qm  = 1'b0;
        o_load_a   = 1'b0;
        o_sub      = 1'b0;
        o_sel_2m   = 1'b0;
        o_shift_aq = 1'b0;
        o_done     = '0;

        case (r_state)
            StLoad: o_load_qm = 1'b1;

            StEval: begin
                case (w_triplet)
                    3'b001, 3'b010: begin       // +M
                        o_load_a = 1'b1;
                    end
                    3'b011: begin               // +2M
                        o_load_a = 1'b1;
                        o_sel_2m = 1'b1;
                    end
                    3'b100: begin               // -2M
                        o_load_a = 1'b1;
                        o_sub    = 1'b1;
                        o_sel_2m = 1'b1;
                    end
                    3'b101, 3'b110: begin       // -M
                        o_load_a = 1'b1;
                        o_sub    = 1'b1;
                    end
                    default: ;                  // 000/111: digit 0, A unchanged
                endcase
            end

            StShift: o_shift_aq = 1'b1;

            StDone: o_done = r_grant;

            default: ;
        endcase
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state != StIdle);

    // -------------------------------------------------------------------------
    // Completed-job counter
    // -------------------------------------------------------------------------
`ifdef BOOTH_SCHED_PERF_CNT_EN
    logic [15:0] r_jobs_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jobs_done <= '0;
        end else if ((r_state == StDone) && (r_jobs_done != 16'hFFFF)) begin
            r_jobs_done <= r_jobs_done + 16'd1;
        end
    end

    assign o_jobs_done = r_jobs_done;
`else
    // Counter not built; aborted and completed jobs are not tallied.
`endif

endmodule

// File: tb/tb_booth_mul_sched.sv
module tb_booth_mul_sched;

    localparam int N_REQ    = 2;
    localparam int WIDTH    = 8;
    localparam int ITER     = WIDTH / 2;
    localparam int DONE_CYC = 2 * ITER + 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic             busy;
    logic             q1;
    logic             q0;
    logic             q_m1;
    logic             load_qm;
    logic             load_a;
    logic             sub;
    logic             sel_2m;
    logic             shift_aq;
`ifdef BOOTH_SCHED_PERF_CNT_EN
    logic [15:0]      jobs_done;
`endif

    always #5 clk = ~clk;

    booth_mul_sched #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (req),
        .o_grant    (grant),
        .o_done     (done),
        .o_busy     (busy),
        .i_q1       (q1),
        .i_q0       (q0),
        .i_q_m1     (q_m1),
        .o_load_qm  (load_qm),
        .o_load_a   (load_a),
        .o_sub      (sub),
        .o_sel_2m   (sel_2m),
`ifdef BOOTH_SCHED_PERF_CNT_EN
        .o_jobs_done(jobs_done),
`endif
        .o_shift_aq (shift_aq)
    );

    int total = 0;
    int bad   = 0;
    int rr_ptr = 0;

    logic [WIDTH-1:0] opa [N_REQ];
    logic [WIDTH-1:0] opb [N_REQ];

    logic       ovr_en = 1'b0;
    logic [2:0] ovr_t  = 3'b000;
    logic [2:0] pats [4];
    logic [2:0] exps [4];
    logic [N_REQ-1:0] g0, g1, g2;

    // Behavioural Booth datapath driven by the sequencer controls.
    logic signed [WIDTH+1:0]   m_a;
    logic [WIDTH-1:0]          m_q;
    logic                      m_qm1;
    logic [WIDTH-1:0]          m_m;
    logic signed [WIDTH+1:0]   m_add;
    logic signed [2*WIDTH+2:0] m_sh;
    int                        m_sel;

    assign q1   = ovr_en ? ovr_t[2] : m_q[1];
    assign q0   = ovr_en ? ovr_t[1] : m_q[0];
    assign q_m1 = ovr_en ? ovr_t[0] : m_qm1;

    always @(posedge clk) begin
        m_sel = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) m_sel = i;
        end
        m_add = {{2{m_m[WIDTH-1]}}, m_m};
        if (sel_2m) m_add = m_add * 2;
        if (load_qm) begin
            m_a   <= '0;
            m_q   <= opb[m_sel];
            m_m   <= opa[m_sel];
            m_qm1 <= 1'b0;
        end else if (load_a) begin
            m_a <= sub ? m_a - m_add : m_a + m_add;
        end else if (shift_aq) begin
            m_sh = {m_a, m_q, m_qm1};
            m_sh = m_sh >>> 2;
            {m_a, m_q, m_qm1} <= m_sh;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return 0;
    endfunction

    task automatic do_reset();
        req    = '0;
        ovr_en = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ctl", 32'({load_qm, load_a, sub, sel_2m, shift_aq, done}), 32'(0));
        reset  = 1'b0;
        rr_ptr = 0;
    endtask

    // Starts at an idle cycle (cycle 0), returns at cycle 2*ITER+3 (idle).
    task automatic run_job(input logic [N_REQ-1:0] r, output logic [N_REQ-1:0] gseen);
        int g;
        int pa, pb, dig;
        logic [N_REQ-1:0]   one;
        logic [N_REQ-1:0]   gexp;
        logic [2*WIDTH-1:0] pexp;
        one   = 1;
        g     = rr_pick(r, rr_ptr);
        gexp  = one << g;
        gseen = '0;
        for (int i = 0; i < N_REQ; i++) begin
            opa[i] = WIDTH'($urandom);
            opb[i] = WIDTH'($urandom);
        end
        req = r;
        for (int n = 1; n <= DONE_CYC + 1; n++) begin
            @(negedge clk);
            if (n == 1) gseen = grant;
            if (n <= DONE_CYC) begin
                chk("job_grant", 32'(grant), 32'(gexp));
                chk("job_busy", 32'(busy), 32'(1));
            end else begin
                chk("idle_grant", 32'(grant), 32'(0));
                chk("idle_busy", 32'(busy), 32'(0));
            end
            chk("load_qm", 32'(load_qm), 32'(n == 1));
            chk("shift_aq", 32'(shift_aq), 32'(n >= 3 && n < DONE_CYC && n % 2 == 1));
            chk("done", 32'(done), (n == DONE_CYC) ? 32'(gexp) : 32'(0));
            if (n >= 2 && n < DONE_CYC && n % 2 == 0) begin
                dig = int'(q0) + int'(q_m1) - 2 * int'(q1);
                chk("eval_load_a", 32'(load_a), 32'(dig != 0));
                chk("eval_sub", 32'(sub), 32'(dig < 0));
                chk("eval_sel_2m", 32'(sel_2m), 32'(dig == 2 || dig == -2));
            end else begin
                chk("ctl_off", 32'({load_a, sub, sel_2m}), 32'(0));
            end
            if (n == DONE_CYC) begin
                pa   = int'($signed(opa[g]));
                pb   = int'($signed(opb[g]));
                pexp = (2 * WIDTH)'(pa * pb);
                chk("product", 32'({m_a[WIDTH-1:0], m_q}), 32'(pexp));
            end
        end
        rr_ptr = (g + 1) % N_REQ;
    endtask

    // Drops the owner's request in the first SHIFT cycle; returns at cycle 4.
    task automatic abort_job(input logic [N_REQ-1:0] r);
        int g;
        logic [N_REQ-1:0] one;
        logic [N_REQ-1:0] gexp;
        one  = 1;
        g    = rr_pick(r, rr_ptr);
        gexp = one << g;
        req  = r;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n <= 3) begin
                chk("abort_grant", 32'(grant), 32'(gexp));
                chk("abort_busy", 32'(busy), 32'(1));
            end else begin
                chk("abort_idle_grant", 32'(grant), 32'(0));
                chk("abort_idle_busy", 32'(busy), 32'(0));
            end
            chk("abort_no_done", 32'(done), 32'(0));
            if (n == 3) begin
                chk("abort_shift", 32'(shift_aq), 32'(1));
                req = r & ~gexp;
            end
        end
        rr_ptr = (g + 1) % N_REQ;
    endtask

    initial begin
        pats = '{3'b011, 3'b100, 3'b111, 3'b101};
        exps = '{3'b101, 3'b111, 3'b000, 3'b110};
        #1;

        // Single requester, full latency profile and product.
        do_reset();
        run_job(2'b01, g0);
        chk("t1_grant", 32'(g0), 32'(2'b01));

        // Forced Booth triplets in EVAL.
        do_reset();
        ovr_en = 1'b1;
        req    = 2'b01;
        for (int n = 1; n <= DONE_CYC; n++) begin
            @(negedge clk);
            if (n >= 2 && n < DONE_CYC && n % 2 == 0) begin
                ovr_t = pats[n / 2 - 1];
                #1;
                chk("triplet_ctl", 32'({load_a, sub, sel_2m}), 32'(exps[n / 2 - 1]));
            end else if (n >= 3 && n < DONE_CYC) begin
                chk("triplet_shift_ctl", 32'({load_a, sub, sel_2m}), 32'(0));
            end
        end
        ovr_en = 1'b0;

        // Both requesting: alternating grants, back to back.
        do_reset();
        run_job(2'b11, g0);
        run_job(2'b11, g1);
        run_job(2'b11, g2);
        chk("t3_grant0", 32'(g0), 32'(2'b01));
        chk("t3_grant1", 32'(g1), 32'(2'b10));
        chk("t3_grant2", 32'(g2), 32'(2'b01));

        // Abort, then the pointer has moved past requester 0.
        do_reset();
        abort_job(2'b01);
        run_job(2'b11, g0);
        chk("t4_grant_after_abort", 32'(g0), 32'(2'b10));

        // Asynchronous reset mid-EVAL.
        do_reset();
        req = 2'b01;
        repeat (4) @(negedge clk);
        chk("t5_busy_pre", 32'(busy), 32'(1));
        #2 reset = 1'b1;
        #1;
        chk("t5_grant", 32'(grant), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_ctl", 32'({load_qm, load_a, sub, sel_2m, shift_aq, done}), 32'(0));
        @(negedge clk);
        chk("t5_no_done", 32'(done), 32'(0));
        req    = 2'b10;
        reset  = 1'b0;
        rr_ptr = 0;
        run_job(2'b10, g0);
        chk("t5_grant_after", 32'(g0), 32'(2'b10));

`ifdef BOOTH_SCHED_PERF_CNT_EN
        do_reset();
        chk("perf_reset", 32'(jobs_done), 32'(0));
        run_job(2'b01, g0);
        run_job(2'b01, g0);
        run_job(2'b01, g0);
        abort_job(2'b01);
        chk("perf_three", 32'(jobs_done), 32'(3));
        force dut.r_jobs_done = 16'hFFFE;
        @(negedge clk);
        release dut.r_jobs_done;
        run_job(2'b01, g0);
        run_job(2'b01, g0);
        chk("perf_saturate", 32'(jobs_done), 32'(16'hFFFF));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
Sequencer and round-robin arbiter for the shared radix-4 Booth multiplier datapath (A/Q/M registers, adder/subtractor, M/2M mux).
- Grants the datapath to one of N_REQ requesters and drives the load/evaluate/shift control sequence for WIDTH/2 iterations.
- Pulses done to the winning requester on completion.
- Sits between the requester operand mux (steered by grant) and the datapath.

Parameters:
N_REQ, 2, number of requesters (2..8)
WIDTH, 8, multiplier operand width; must be even, >= 4; ITER = WIDTH/2 Booth iterations

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  request per requester; held high until done or abort
grant  out  N_REQ  one-hot grant, selects operand mux; all-zero when idle
done  out  N_REQ  one-cycle completion pulse to granted requester
busy  out  1  high whenever state != IDLE
q1  in  1  datapath Q[1]
q0  in  1  datapath Q[0]
q_m1  in  1  datapath Q[-1]
load_qm  out  1  load Q, M from operands; clear A and Q[-1]
load_a  out  1  write adder result into A
sub  out  1  adder subtracts (A - sel)
sel_2m  out  1  adder operand is 2M (else M)
shift_aq  out  1  arithmetic shift A:Q:Q[-1] right by 2

Behaviour:
- Reset value of every output and register is 0: state IDLE, grant 0, rr pointer 0, iteration counter 0, busy 0, all control outputs 0.
- Reset is asynchronous and immediate, including mid-operation; no done is issued for an aborted job.
- States: IDLE, LOAD, EVAL, SHIFT, DONE. State, grant register, rr pointer and iteration counter are registered. Control outputs are combinational from state, and from q1/q0/q_m1 in EVAL.
- IDLE: if any req bit is high, select the first requester at or after rr pointer (cyclic), register grant one-hot, go LOAD. Otherwise stay.
- LOAD: load_qm=1 for one cycle; counter <= 0; go EVAL.
- EVAL, Booth triplet t={q1,q0,q_m1}:
  - t=000/111: load_a=0, sub=0, sel_2m=0.
  - t=001/010: load_a=1, sub=0, sel_2m=0.
  - t=011: load_a=1, sub=0, sel_2m=1.
  - t=100: load_a=1, sub=1, sel_2m=1.
  - t=101/110: load_a=1, sub=1, sel_2m=0.
  - Go SHIFT.
- Outside EVAL, load_a, sub and sel_2m are all 0.
- SHIFT: shift_aq=1. If counter == ITER-1, go DONE; else counter++ and go EVAL.
- DONE: done = grant for exactly one cycle. rr pointer <= granted index + 1 (mod N_REQ). grant cleared on exit; go IDLE. A new job may be granted in the following IDLE cycle.
- grant is stable and non-zero from LOAD through DONE inclusive; it never changes mid-job.
- Latency: req sampled in IDLE at cycle 0 → LOAD cycle 1 → EVAL/SHIFT pairs occupy cycles 2..2*ITER+1 → DONE cycle 2*ITER+2 (WIDTH=8: done at cycle 10).
- Abort: if req[granted] is low in LOAD, EVAL or SHIFT, go IDLE next cycle. grant clears, no done, rr pointer still advances past the aborted requester.
- req bits for non-granted requesters are ignored while busy.
- Simultaneous requests: rr pointer decides; starvation-free, each waiting requester is served within N_REQ jobs.
- Control outputs are mutually exclusive by state: at most one of load_qm, load_a, shift_aq is high in any cycle.

Optional Feature:
BOOTH_SCHED_PERF_CNT_EN
- Defined: adds output jobs_done [15:0]. Increments once per DONE cycle, saturates at 16'hFFFF, reset to 0. Not incremented on abort.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- WIDTH=8, N_REQ=2, req=01 held from cycle 0 → grant=01 cycles 1-10, load_qm=1 cycle 1, shift_aq=1 cycles 3,5,7,9, done=01 only at cycle 10, busy low at cycle 11.
- In EVAL, drive {q1,q0,q_m1} = 011, 100, 111, 101 → (load_a,sub,sel_2m) = (1,0,1), (1,1,1), (0,0,0), (1,1,0); all three are 0 in the following SHIFT cycle.
- req=11 held continuously after reset → grants alternate 01, 10, 01; each done pulse matches the preceding grant; one idle cycle between jobs.
- req=01, drop req[0] in the first SHIFT cycle (cycle 3) → state IDLE at cycle 4, grant=00, no done; a subsequent req=11 is granted to requester 1 first.
- Assert reset asynchronously mid-EVAL (cycle 4) → all outputs 0 immediately, no done; after release with req=10, normal job completes with done=10 at cycle 10 relative to its start.
- BOOTH_SCHED_PERF_CNT_EN defined: three completed jobs plus one aborted job → jobs_done=3; preload counter near saturation by simulation force at 16'hFFFE, run two jobs → jobs_done=16'hFFFF.
